// File: rtl/spi_slave.sv
// SPI slave front end for a small memory: receives 10-bit command/address/data
// words on MOSI and returns 8-bit read data on MISO. Everything runs on clk.
module spi_slave (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       SS_n,
   input  logic       MOSI,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       MISO,
   output logic [9:0] rx_data,
   output logic       rx_valid
);

   typedef enum logic [2:0] {
      IDLE,
      CHK_CMD,
      WRITE,
      READ_ADD,
      READ_DATA
   } state_t;

   typedef enum logic [1:0] {
      TX_OFF,
      TX_WAIT,
      TX_SHIFT
   } tx_phase_t;

   state_t     state;
   state_t     next_state;
   tx_phase_t  tx_phase;
   logic       rd_addr_seen;
   logic       rx_done;
   logic [3:0] bit_cnt;
   logic [8:0] rx_shift;
   logic [2:0] tx_cnt;
   logic [6:0] tx_shift;

   // NOTE: every variable driven here gets a default first so no latch is inferred.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (!SS_n) next_state = CHK_CMD;
         CHK_CMD: begin
            if (SS_n)              next_state = IDLE;
            else if (!MOSI)        next_state = WRITE;
            else if (rd_addr_seen) next_state = READ_DATA;
            else                   next_state = READ_ADD;
         end
         WRITE, READ_ADD, READ_DATA: if (SS_n) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         tx_phase     <= TX_OFF;
         rd_addr_seen <= 1'b0;
         rx_done      <= 1'b0;
         bit_cnt      <= 4'd0;
         rx_shift     <= 9'd0;
         tx_cnt       <= 3'd0;
         tx_shift     <= 7'd0;
         rx_data      <= 10'h000;
         rx_valid     <= 1'b0;
         MISO         <= 1'b0;
      end else begin
         state    <= next_state;
         rx_valid <= 1'b0;
         if (SS_n) begin
            // Deselect abandons the frame and any pending read reply.
            rx_done  <= 1'b0;
            bit_cnt  <= 4'd0;
            tx_phase <= TX_OFF;
            tx_cnt   <= 3'd0;
            MISO     <= 1'b0;
         end else begin
            case (state)
               CHK_CMD: begin
                  rx_shift <= {8'd0, MOSI};
                  bit_cnt  <= 4'd9;
                  rx_done  <= 1'b0;
               end
               WRITE, READ_ADD, READ_DATA: begin
                  if (!rx_done) begin
                     rx_shift <= {rx_shift[7:0], MOSI};
                     bit_cnt  <= bit_cnt - 4'd1;
                     if (bit_cnt == 4'd1) begin
                        rx_data  <= {rx_shift, MOSI};
                        rx_valid <= 1'b1;
                        rx_done  <= 1'b1;
                        if (state == READ_ADD) rd_addr_seen <= 1'b1;
                        if (state == READ_DATA) begin
                           rd_addr_seen <= 1'b0;
                           tx_phase     <= TX_WAIT;
                        end
                     end
                  end else if (state == READ_DATA) begin
                     case (tx_phase)
                        TX_WAIT: begin
                           if (tx_valid) begin
                              tx_shift <= tx_data[6:0];
                              MISO     <= tx_data[7];
                              tx_cnt   <= 3'd7;
                              tx_phase <= TX_SHIFT;
                           end
                        end
                        TX_SHIFT: begin
                           if (tx_cnt != 3'd0) begin
                              MISO     <= tx_shift[6];
                              tx_shift <= {tx_shift[5:0], 1'b0};
                              tx_cnt   <= tx_cnt - 3'd1;
                           end else begin
                              MISO     <= 1'b0;
                              tx_phase <= TX_OFF;
                           end
                        end
                        default: ;
                     endcase
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: directed frames plus randomized frames,
// checked against a frame-level model of the protocol.
module tb_spi_slave;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       SS_n;
   logic       MOSI;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       MISO;
   logic [9:0] rx_data;
   logic       rx_valid;

   int n_tests = 0;
   int n_fail  = 0;

   // Frame-level model: address-seen flag and last completed word.
   bit         mdl_seen;
   logic [9:0] mdl_rx;

   always #5 clk = ~clk;

   spi_slave dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .SS_n     (SS_n),
      .MOSI     (MOSI),
      .tx_valid (tx_valid),
      .tx_data  (tx_data),
      .MISO     (MISO),
      .rx_data  (rx_data),
      .rx_valid (rx_valid)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Full frame; optionally resets the block after rst_after MISO bits.
   task automatic send_frame(input logic [9:0] word, input logic [7:0] txd,
                             input int tx_delay, input int rst_after);
      bit   rd_data_path;
      logic exp_bit;
      rd_data_path = word[9] && mdl_seen;

      SS_n = 1'b0; MOSI = 1'($urandom); tx_valid = 1'b0;
      tick();
      check("start_miso", MISO, 16'(0));
      for (int i = 9; i >= 0; i--) begin
         MOSI     = word[i];
         tx_valid = (i > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
         tx_data  = 8'($urandom);
         tick();
         check("miso_during_rx", MISO, 16'(0));
         if (i > 0) check("rx_valid_early", rx_valid, 16'(0));
      end
      check("rx_valid", rx_valid, 16'(1));
      check("rx_data", rx_data, 16'(word));
      mdl_rx = word;
      if (word[9]) mdl_seen = !rd_data_path;

      tx_valid = 1'b0;
      for (int w = 0; w < tx_delay; w++) begin
         MOSI = 1'($urandom);
         tick();
         check("rx_valid_pulse", rx_valid, 16'(0));
         check("miso_wait", MISO, 16'(0));
         check("rx_data_hold", rx_data, 16'(word));
      end

      for (int b = 7; b >= 0; b--) begin
         if (b == 7) begin
            tx_valid = 1'b1; tx_data = txd;
         end else begin
            tx_valid = 1'($urandom_range(0, 1)); tx_data = 8'($urandom);
         end
         MOSI = 1'($urandom);
         tick();
         exp_bit = rd_data_path ? txd[b] : 1'b0;
         check("miso_bit", MISO, 16'(exp_bit));
         if (8 - b == rst_after) begin
            rst_n = 1'b0; tx_valid = 1'b0;
            tick();
            check("rst_miso", MISO, 16'(0));
            check("rst_rx_valid", rx_valid, 16'(0));
            check("rst_rx_data", rx_data, 16'(0));
            mdl_seen = 1'b0;
            mdl_rx   = 10'h000;
            rst_n = 1'b1; SS_n = 1'b1;
            tick();
            check("post_rst_miso", MISO, 16'(0));
            return;
         end
      end

      for (int t = 0; t < 2; t++) begin
         tx_valid = 1'($urandom_range(0, 1)); tx_data = 8'($urandom);
         MOSI = 1'($urandom);
         tick();
         check("tail_miso", MISO, 16'(0));
         check("tail_rx_valid", rx_valid, 16'(0));
         check("tail_rx_data", rx_data, 16'(word));
      end

      SS_n = 1'b1; tx_valid = 1'b0;
      tick();
      check("end_miso", MISO, 16'(0));
      check("end_rx_valid", rx_valid, 16'(0));
      tick();
   endtask

   // Frame cut short: nbits bits sent, then SS_n rises on the next edge.
   task automatic abort_frame(input logic [9:0] word, input int nbits);
      SS_n = 1'b0; tx_valid = 1'b0; MOSI = 1'($urandom);
      tick();
      for (int k = 0; k < nbits; k++) begin
         MOSI = word[9 - k];
         tick();
         check("abort_rx_valid_early", rx_valid, 16'(0));
         check("abort_miso_early", MISO, 16'(0));
      end
      SS_n = 1'b1;
      MOSI = word[9 - nbits];
      tick();
      check("abort_rx_valid", rx_valid, 16'(0));
      check("abort_rx_data", rx_data, 16'(mdl_rx));
      check("abort_miso", MISO, 16'(0));
      tick();
   endtask

   initial begin
      logic [9:0] w;
      rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
      mdl_seen = 1'b0; mdl_rx = 10'h000;
      tick();
      tick();
      check("reset_miso", MISO, 16'(0));
      check("reset_rx_valid", rx_valid, 16'(0));
      check("reset_rx_data", rx_data, 16'(0));
      rst_n = 1'b1;
      tick();

      // Write address and write data frames.
      send_frame(10'h05A, 8'($urandom), 1, -1);
      send_frame(10'h1C3, 8'($urandom), 1, -1);

      // Read address, read data with reply A5, then read address again.
      send_frame(10'h25A, 8'h5C, 1, -1);
      w = 10'h300 | 10'($urandom_range(0, 255));
      send_frame(w, 8'hA5, 1, -1);
      send_frame(10'h2C1, 8'hFF, 1, -1);

      // Abort after five bits, then a clean frame.
      abort_frame(10'h2AB, 5);
      send_frame(10'h0FF, 8'($urandom), 2, -1);

      // Abort on the bit-0 edge must not clear the address-seen flag.
      abort_frame(10'h3C4, 9);
      send_frame(10'h311, 8'h3C, 1, -1);

      // Reset during the reply, then a read frame takes the address path.
      send_frame(10'h277, 8'h00, 1, -1);
      send_frame(10'h3E0, 8'hC6, 1, 3);
      send_frame(10'h3AA, 8'h81, 1, -1);
      send_frame(10'h355, 8'h69, 3, -1);

      for (int r = 0; r < 24; r++) begin
         w = 10'($urandom);
         if ($urandom_range(0, 3) == 0)
            abort_frame(w, $urandom_range(0, 9));
         else
            send_frame(w, 8'($urandom), $urandom_range(1, 3), -1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
